// File: rtl/tx_polyphase_iq_pkg.sv
// Shared constants, tap entry type and arithmetic helpers for the polyphase I/Q transmitter.
package tx_polyphase_iq_pkg;

  localparam int UPSAMPLE_DEF   = 4;
  localparam int NCOEF_DEF      = 24;
  localparam int COEF_NBITS_DEF = 8;
  localparam int COEF_FBITS_DEF = 7;
  localparam int OUT_NBITS_DEF  = 8;
  localparam int OUT_FBITS_DEF  = 7;

  localparam int PHASE_W = $clog2(UPSAMPLE_DEF);
  localparam int ADDR_W  = $clog2(NCOEF_DEF);

  // A cleared entry (vld=0) is a stuffed zero symbol and contributes nothing.
  typedef struct packed {
    logic vld;
    logic sym;
  } tap_t;

  function automatic int ntaps(input int ncoef, input int upsample);
    return ncoef / upsample;
  endfunction

  function automatic int acc_nbits(input int coef_nbits, input int n_taps);
    return coef_nbits + $clog2(n_taps) + 1;
  endfunction

  // Returns {sat, value}; value is the truncated sample, sign-extended to 32 bits.
  function automatic logic [32:0] sat_trunc(input logic signed [31:0] acc,
                                            input int shift, input int out_nbits);
    logic signed [31:0] q;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    q  = acc >>> shift;
    hi = (32'sd1 <<< (out_nbits - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (q > hi) return {1'b1, hi};
    if (q < lo) return {1'b1, lo};
    return {1'b0, q};
  endfunction

endpackage

// File: rtl/tx_polyphase_iq_if.sv
// Symbol, coefficient-write and sample bus of the polyphase I/Q transmitter.
interface tx_polyphase_iq_if;
  import tx_polyphase_iq_pkg::*;

  logic                              enable;
  logic                              sym_valid;
  logic                              sym_i;
  logic                              sym_q;
  logic                              sym_ready;
  logic                              coef_we;
  logic [ADDR_W-1:0]                 coef_addr;
  logic signed [COEF_NBITS_DEF-1:0]  coef_data;
  logic signed [OUT_NBITS_DEF-1:0]   tx_i;
  logic signed [OUT_NBITS_DEF-1:0]   tx_q;
  logic                              tx_valid;
  logic [PHASE_W-1:0]                tx_phase;
  logic                              sat_i;
  logic                              sat_q;

  modport master (
    output enable, sym_valid, sym_i, sym_q, coef_we, coef_addr, coef_data,
    input  sym_ready, tx_i, tx_q, tx_valid, tx_phase, sat_i, sat_q
  );

  modport slave (
    input  enable, sym_valid, sym_i, sym_q, coef_we, coef_addr, coef_data,
    output sym_ready, tx_i, tx_q, tx_valid, tx_phase, sat_i, sat_q
  );

endinterface

// File: rtl/tx_polyphase_iq_fir_branch.sv
// One rail of the polyphase FIR: symbol buffer plus accumulate/saturate for the current phase.
module tx_polyphase_iq_fir_branch
  import tx_polyphase_iq_pkg::*;
#(
  parameter int UPSAMPLE   = UPSAMPLE_DEF,
  parameter int NCOEF      = NCOEF_DEF,
  parameter int COEF_NBITS = COEF_NBITS_DEF,
  parameter int COEF_FBITS = COEF_FBITS_DEF,
  parameter int OUT_NBITS  = OUT_NBITS_DEF,
  parameter int OUT_FBITS  = OUT_FBITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_shift,
  input  logic                          i_sym_valid,
  input  logic                          i_sym_bit,
  input  logic [$clog2(UPSAMPLE)-1:0]   i_phase,
  input  logic signed [COEF_NBITS-1:0]  i_coef [NCOEF],
  output logic signed [OUT_NBITS-1:0]   o_value,
  output logic                          o_sat
);

  localparam int NTAPS     = ntaps(NCOEF, UPSAMPLE);
  localparam int ACC_NBITS = acc_nbits(COEF_NBITS, NTAPS);
  localparam int AW        = $clog2(NCOEF);

  tap_t                        r_buf  [NTAPS];
  tap_t                        w_tap  [NTAPS];
  logic signed [ACC_NBITS-1:0] w_term [NTAPS];
  logic signed [ACC_NBITS-1:0] w_acc;
  logic [32:0]                 w_st;
  logic                        w_unused;

  // On an acceptance edge the incoming symbol already feeds the phase-0 sample.
  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_tap
      logic [AW-1:0]               w_idx;
      logic signed [COEF_NBITS-1:0] w_c;
      if (gi == 0) begin : g_head
        assign w_tap[gi] = i_shift ? tap_t'{vld: i_sym_valid, sym: i_sym_bit} : r_buf[gi];
      end else begin : g_body
        assign w_tap[gi] = i_shift ? r_buf[gi-1] : r_buf[gi];
      end
      assign w_idx = AW'(gi * UPSAMPLE) + AW'(i_phase);
      assign w_c   = i_coef[w_idx];
      assign w_term[gi] = !w_tap[gi].vld ? '0 :
                          w_tap[gi].sym  ? {{(ACC_NBITS-COEF_NBITS){w_c[COEF_NBITS-1]}}, w_c} :
                                          -{{(ACC_NBITS-COEF_NBITS){w_c[COEF_NBITS-1]}}, w_c};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NTAPS; t++) r_buf[t] <= '0;
    end else if (i_shift) begin
      for (int t = 0; t < NTAPS; t++) r_buf[t] <= w_tap[t];
    end
  end

  always_comb begin
    w_acc = '0;
    for (int t = 0; t < NTAPS; t++) w_acc = w_acc + w_term[t];
  end

  assign w_st     = sat_trunc(32'(w_acc), COEF_FBITS - OUT_FBITS, OUT_NBITS);
  assign o_sat    = w_st[32];
  assign o_value  = w_st[OUT_NBITS-1:0];
  assign w_unused = ^w_st[31:OUT_NBITS];

endmodule

// File: rtl/tx_polyphase_iq.sv
// Two-rail polyphase pulse-shaping transmitter: phase counter, symbol handshake,
// runtime coefficient register file and registered saturated outputs.
module tx_polyphase_iq
  import tx_polyphase_iq_pkg::*;
#(
  parameter int UPSAMPLE   = UPSAMPLE_DEF,
  parameter int NCOEF      = NCOEF_DEF,
  parameter int COEF_NBITS = COEF_NBITS_DEF,
  parameter int COEF_FBITS = COEF_FBITS_DEF,
  parameter int OUT_NBITS  = OUT_NBITS_DEF,
  parameter int OUT_FBITS  = OUT_FBITS_DEF,
  parameter logic [NCOEF*COEF_NBITS-1:0] COEF_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  tx_polyphase_iq_if.slave bus
);

  localparam int PW = $clog2(UPSAMPLE);
  localparam int AW = $clog2(NCOEF);

  logic [PW-1:0]                r_phase;
  logic signed [COEF_NBITS-1:0] r_coef [NCOEF];
  logic signed [OUT_NBITS-1:0]  r_tx_i;
  logic signed [OUT_NBITS-1:0]  r_tx_q;
  logic                         r_tx_valid;
  logic [PW-1:0]                r_tx_phase;
  logic                         r_sat_i;
  logic                         r_sat_q;

  logic                         w_shift;
  logic signed [OUT_NBITS-1:0]  w_val_i;
  logic signed [OUT_NBITS-1:0]  w_val_q;
  logic                         w_sat_i;
  logic                         w_sat_q;

  assign w_shift       = bus.enable && (r_phase == '0);
  assign bus.sym_ready = w_shift;

  // UPSAMPLE is a power of two, so the counter wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_phase <= '0;
    else if (bus.enable) r_phase <= r_phase + 1'b1;
  end

  // Addresses beyond NCOEF-1 match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCOEF; k++)
        r_coef[k] <= COEF_INIT[(NCOEF-1-k)*COEF_NBITS +: COEF_NBITS];
    end else if (bus.coef_we) begin
      for (int k = 0; k < NCOEF; k++)
        if (bus.coef_addr == AW'(k)) r_coef[k] <= bus.coef_data;
    end
  end

  tx_polyphase_iq_fir_branch #(
    .UPSAMPLE(UPSAMPLE), .NCOEF(NCOEF), .COEF_NBITS(COEF_NBITS),
    .COEF_FBITS(COEF_FBITS), .OUT_NBITS(OUT_NBITS), .OUT_FBITS(OUT_FBITS)
  ) u_fir_i (
    .clk(clk), .rst_n(rst_n), .i_shift(w_shift), .i_sym_valid(bus.sym_valid),
    .i_sym_bit(bus.sym_i), .i_phase(r_phase), .i_coef(r_coef),
    .o_value(w_val_i), .o_sat(w_sat_i)
  );

  tx_polyphase_iq_fir_branch #(
    .UPSAMPLE(UPSAMPLE), .NCOEF(NCOEF), .COEF_NBITS(COEF_NBITS),
    .COEF_FBITS(COEF_FBITS), .OUT_NBITS(OUT_NBITS), .OUT_FBITS(OUT_FBITS)
  ) u_fir_q (
    .clk(clk), .rst_n(rst_n), .i_shift(w_shift), .i_sym_valid(bus.sym_valid),
    .i_sym_bit(bus.sym_q), .i_phase(r_phase), .i_coef(r_coef),
    .o_value(w_val_q), .o_sat(w_sat_q)
  );

  // A stalled cycle drops tx_valid but leaves the last sample on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_i     <= '0;
      r_tx_q     <= '0;
      r_tx_valid <= 1'b0;
      r_tx_phase <= '0;
      r_sat_i    <= 1'b0;
      r_sat_q    <= 1'b0;
    end else if (bus.enable) begin
      r_tx_i     <= w_val_i;
      r_tx_q     <= w_val_q;
      r_tx_valid <= 1'b1;
      r_tx_phase <= r_phase;
      r_sat_i    <= w_sat_i;
      r_sat_q    <= w_sat_q;
    end else begin
      r_tx_valid <= 1'b0;
    end
  end

  assign bus.tx_i     = r_tx_i;
  assign bus.tx_q     = r_tx_q;
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_phase = r_tx_phase;
  assign bus.sat_i    = r_sat_i;
  assign bus.sat_q    = r_sat_q;

endmodule

// File: tb/tb_tx_polyphase_iq.sv
// Scoreboard bench for tx_polyphase_iq: a behavioural model predicts every sample.
module tb_tx_polyphase_iq;
  import tx_polyphase_iq_pkg::*;

  localparam int NC = 24;
  localparam int UP = 4;
  localparam int NT = 6;

  function automatic logic [NC*8-1:0] make_init();
    logic [NC*8-1:0] v;
    v = '0;
    for (int k = 0; k < NC; k++) v[(NC-1-k)*8 +: 8] = 8'(k + 1);
    return v;
  endfunction

  localparam logic [NC*8-1:0] INIT = make_init();

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_polyphase_iq_if bus();

  tx_polyphase_iq #(.COEF_INIT(INIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int vi;
    int vq;
    bit si;
    bit sq;
    int ph;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_coef[NC];
  bit   m_v[NT];
  bit   m_bi[NT];
  bit   m_bq[NT];
  int   m_phase;
  int   last_i, last_q, last_ph;
  bit   last_si, last_sq;
  int   ready_cnt;

  function automatic void clip8(input int acc, output int v, output bit s);
    s = (acc > 127) || (acc < -128);
    v = (acc > 127) ? 127 : (acc < -128) ? -128 : acc;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_coef[k] = k + 1;
    for (int t = 0; t < NT; t++) begin m_v[t] = 0; m_bi[t] = 0; m_bq[t] = 0; end
    m_phase = 0;
    sb.delete();
    last_i = 0; last_q = 0; last_ph = 0; last_si = 0; last_sq = 0;
  endtask

  // One clock of stimulus; predicts, then compares what the DUT registered.
  task automatic cycle(input bit en, input bit sv, input bit si, input bit sq,
                       input bit we = 1'b0, input int addr = 0, input int data = 0);
    exp_t e;
    bit nv[NT], nbi[NT], nbq[NT];
    int ai, aq, c;
    bus.enable = en; bus.sym_valid = sv; bus.sym_i = si; bus.sym_q = sq;
    bus.coef_we = we; bus.coef_addr = 5'(addr); bus.coef_data = 8'(data);
    #1;
    n_tests++;
    if (bus.sym_ready !== (en && m_phase == 0)) begin
      n_fail++;
      $display("FAIL sym_ready: got %b want %b", bus.sym_ready, (en && m_phase == 0));
    end
    if (bus.sym_ready === 1'b1) ready_cnt++;
    nv = m_v; nbi = m_bi; nbq = m_bq;
    if (en && m_phase == 0) begin
      for (int t = NT - 1; t > 0; t--) begin nv[t] = m_v[t-1]; nbi[t] = m_bi[t-1]; nbq[t] = m_bq[t-1]; end
      nv[0] = sv; nbi[0] = si; nbq[0] = sq;
    end
    if (en) begin
      ai = 0; aq = 0;
      for (int t = 0; t < NT; t++) begin
        c = m_coef[t*UP + m_phase];
        if (nv[t]) begin ai += nbi[t] ? c : -c; aq += nbq[t] ? c : -c; end
      end
      clip8(ai, e.vi, e.si);
      clip8(aq, e.vq, e.sq);
      e.ph = m_phase;
      sb.push_back(e);
      m_v = nv; m_bi = nbi; m_bq = nbq;
      m_phase = (m_phase + 1) % UP;
    end
    if (we && addr >= 0 && addr < NC) m_coef[addr] = data;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.tx_valid !== en) begin
      n_fail++;
      $display("FAIL tx_valid: got %b want %b", bus.tx_valid, en);
    end
    if (bus.tx_valid === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: sample seen, got none expected, want none");
      end else begin
        e = sb.pop_front();
        if (bus.tx_i !== 8'(e.vi) || bus.tx_q !== 8'(e.vq) || bus.sat_i !== e.si ||
            bus.sat_q !== e.sq || bus.tx_phase !== 2'(e.ph)) begin
          n_fail++;
          $display("FAIL sample: got i=%0d q=%0d sat=%b%b ph=%0d want i=%0d q=%0d sat=%b%b ph=%0d",
                   bus.tx_i, bus.tx_q, bus.sat_i, bus.sat_q, bus.tx_phase,
                   e.vi, e.vq, e.si, e.sq, e.ph);
        end
        $display("[TB] txn ph=%0d i=%0d q=%0d sat=%b%b", bus.tx_phase, bus.tx_i, bus.tx_q,
                 bus.sat_i, bus.sat_q);
      end
      last_i = int'(bus.tx_i); last_q = int'(bus.tx_q); last_ph = int'(bus.tx_phase);
      last_si = bus.sat_i; last_sq = bus.sat_q;
    end else begin
      n_tests++;
      if (bus.tx_i !== 8'(last_i) || bus.tx_q !== 8'(last_q)) begin
        n_fail++;
        $display("FAIL hold: got i=%0d q=%0d want i=%0d q=%0d", bus.tx_i, bus.tx_q, last_i, last_q);
      end
    end
  endtask

  // Called at posedge+1; asserts reset between edges and releases it later.
  task automatic do_reset(input bit check);
    #2;
    rst_n = 1'b0;
    #1;
    if (check) begin
      n_tests++;
      if (bus.tx_i !== 8'sd0 || bus.tx_q !== 8'sd0 || bus.tx_valid !== 1'b0 ||
          bus.tx_phase !== 2'd0 || bus.sat_i !== 1'b0 || bus.sat_q !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out: got i=%0d q=%0d v=%b ph=%0d sat=%b%b want all 0",
                 bus.tx_i, bus.tx_q, bus.tx_valid, bus.tx_phase, bus.sat_i, bus.sat_q);
      end
    end
    bus.enable = 1'b0; bus.sym_valid = 1'b0; bus.coef_we = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic align();
    while (m_phase != 0) cycle(1, 0, 0, 0);
  endtask

  task automatic stream(input int n);
    bit b;
    for (int k = 0; k < n; k++) begin
      b = 1'($urandom);
      cycle(1, 1, b, 1'($urandom));
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    do_reset(1);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 1);
  endtask

  task automatic test_impulse();
    int expv;
    for (int k = 0; k < 28; k++) begin
      if (k == 0) cycle(1, 1, 1, 0);
      else        cycle(1, 0, 0, 0);
      expv = (k < 24) ? k + 1 : 0;
      n_tests++;
      if (last_i != expv || last_q != -expv) begin
        n_fail++;
        $display("FAIL impulse[%0d]: got i=%0d q=%0d want i=%0d q=%0d", k, last_i, last_q, expv, -expv);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset(0);
    for (int k = 0; k < NC; k++) cycle(1, 0, 0, 0, 1, k, 127);
    align();
    cycle(1, 1, 1, 1);
    n_tests++;
    if (last_i != 127 || last_si !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_first: got i=%0d sat=%b want i=127 sat=0", last_i, last_si);
    end
    for (int k = 0; k < 27; k++) cycle(1, 1, 1, 1);
    n_tests++;
    if (last_i != 127 || last_si !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pos: got i=%0d sat=%b want i=127 sat=1", last_i, last_si);
    end
    for (int k = 0; k < 28; k++) cycle(1, 1, 0, 0);
    n_tests++;
    if (last_i != -128 || last_si !== 1'b1 || last_q != -128 || last_sq !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_neg: got i=%0d sat=%b q=%0d sat=%b want -128/1", last_i, last_si, last_q, last_sq);
    end
  endtask

  task automatic test_underrun();
    do_reset(0);
    ready_cnt = 0;
    cycle(1, 1, 1, 1);
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 1);
    n_tests++;
    if (last_i != 5 || last_q != 5) begin
      n_fail++;
      $display("FAIL underrun: got i=%0d q=%0d want 5 5", last_i, last_q);
    end
    for (int k = 0; k < 11; k++) cycle(1, 0, 0, 0);
    n_tests++;
    if (ready_cnt != 4) begin
      n_fail++;
      $display("FAIL ready_rate: got %0d pulses want 4", ready_cnt);
    end
    stream(8);
    cycle(1, 0, 1, 0);
    stream(27);
  endtask

  task automatic test_stall();
    do_reset(0);
    stream(9);
    while (m_phase != 3) stream(1);
    for (int k = 0; k < 3; k++) cycle(0, 1, 1, 0);
    cycle(1, 1, 1, 0);
    n_tests++;
    if (last_ph != 3) begin
      n_fail++;
      $display("FAIL stall_resume: got phase %0d want 3", last_ph);
    end
    stream(14);
  endtask

  task automatic test_coef_write();
    do_reset(0);
    for (int k = 0; k < NC; k++) cycle(1, 1, 1, 0);
    cycle(1, 1, 1, 0, 1, 0, -5);
    n_tests++;
    if (last_i != 66 || last_q != -66) begin
      n_fail++;
      $display("FAIL coef_old: got i=%0d q=%0d want 66 -66", last_i, last_q);
    end
    cycle(1, 1, 1, 0, 1, 24, 99);
    cycle(1, 1, 1, 0);
    cycle(1, 1, 1, 0);
    cycle(1, 1, 1, 0);
    n_tests++;
    if (last_i != 60 || last_q != -60) begin
      n_fail++;
      $display("FAIL coef_new: got i=%0d q=%0d want 60 -60", last_i, last_q);
    end
    stream(12);
  endtask

  task automatic test_async_reset();
    stream(6);
    do_reset(1);
    cycle(1, 1, 1, 0);
    n_tests++;
    if (last_ph != 0 || last_i != 1 || last_q != -1) begin
      n_fail++;
      $display("FAIL reset_restore: got ph=%0d i=%0d q=%0d want 0 1 -1", last_ph, last_i, last_q);
    end
    for (int k = 0; k < 7; k++) cycle(1, 0, 0, 0);
  endtask

  initial begin
    bus.enable = 1'b0; bus.sym_valid = 1'b0; bus.sym_i = 1'b0; bus.sym_q = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    ready_cnt = 0;
    model_reset();
    test_reset();
    test_impulse();
    test_saturation();
    test_underrun();
    test_stall();
    test_coef_write();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
